// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, PC step, fetch FSM states and the queue entry
// layout used by the instruction fetch queue and its storage.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam logic [ADDR_W-1:0] PC_INC = 32'd4;

    // IDLE : waiting for start, no request
    // REQ  : requesting at the fetch PC (request dropped while queue full)
    // DRAIN: old request still outstanding after a redirect, data thrown away
    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_REQ   = 2'd1,
        FS_DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry queue of {pc, instr} fetched words.
//   clk_i, rst_i (async, active-low)
//   clear_i        drop all entries (wins over push/pop)
//   push_i/entry_i write at tail; ignored when full
//   pop_i          drop head; ignored when empty
//   head_o         head entry (zero after reset)
//   count_o        occupancy, full_o when count_o == DEPTH
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  fetch_entry_t               entry_i,
    input  logic                       pop_i,
    output fetch_entry_t               head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic           do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && (count_q != '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= entry_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: fetches sequential instruction words from imem into a
// small queue feeding decode, with redirect (flush) support.
//   clk_i, rst_i (async, active-low)
//   start_i                    begin fetching (latched by leaving IDLE)
//   flush_i, flush_pc_i        redirect: clear queue, restart at flush_pc_i
//   imem_req_o/addr_o/ack_i/data_i  single-outstanding memory handshake
//   instr_valid_o/instr_o/instr_pc_o/instr_ready_i  head toward decode
//   count_o                    queue occupancy
module instr_fetch_queue
    import cpu_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   flush_i,
    input  logic [ADDR_W-1:0]      flush_pc_i,
    output logic                   imem_req_o,
    output logic [ADDR_W-1:0]      imem_addr_o,
    input  logic                   imem_ack_i,
    input  logic [INSTR_W-1:0]     imem_data_i,
    output logic                   instr_valid_o,
    output logic [INSTR_W-1:0]     instr_o,
    output logic [ADDR_W-1:0]      instr_pc_o,
    input  logic                   instr_ready_i,
    output logic [$clog2(DEPTH):0] count_o
);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;        // next address to fetch
    logic [ADDR_W-1:0] stale_q;     // address still on the bus during DRAIN
    logic              fifo_full;
    logic              fire;
    logic              push;
    fetch_entry_t      head;

    // Request is derived from registered state and occupancy only. While a
    // request waits, occupancy can only fall, so it never drops unacked.
    assign imem_req_o  = ((state_q == FS_REQ) && !fifo_full) || (state_q == FS_DRAIN);
    assign imem_addr_o = (state_q == FS_DRAIN) ? stale_q : pc_q;
    assign fire        = imem_req_o && imem_ack_i;
    assign push        = fire && (state_q == FS_REQ) && !flush_i;

    assign instr_valid_o = (count_o != '0);
    assign instr_o       = head.instr;
    assign instr_pc_o    = head.pc;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= FS_IDLE;
            pc_q    <= RESET_PC;
            stale_q <= RESET_PC;
        end else begin
            case (state_q)
                FS_IDLE: begin
                    if (flush_i)      pc_q    <= flush_pc_i;
                    else if (start_i) state_q <= FS_REQ;
                end
                FS_REQ: begin
                    if (flush_i) begin
                        pc_q <= flush_pc_i;
                        // An unacked request must finish at its old address.
                        if (imem_req_o && !imem_ack_i) begin
                            stale_q <= pc_q;
                            state_q <= FS_DRAIN;
                        end
                    end else if (fire) begin
                        pc_q <= pc_q + PC_INC;
                    end
                end
                FS_DRAIN: begin
                    if (flush_i)    pc_q    <= flush_pc_i;
                    if (imem_ack_i) state_q <= FS_REQ;
                end
                default: state_q <= FS_IDLE;
            endcase
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (flush_i),
        .push_i  (push),
        .entry_i ('{pc: pc_q, instr: imem_data_i}),
        .pop_i   (instr_valid_o && instr_ready_i),
        .head_o  (head),
        .count_o (count_o),
        .full_o  (fifo_full)
    );

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i, flush_i, imem_ack_i, instr_ready_i;
    logic [31:0] flush_pc_i, imem_data_i;
    logic        imem_req_o, instr_valid_o;
    logic [31:0] imem_addr_o, instr_o, instr_pc_o;
    logic [2:0]  count_o;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    // Memory returns a word tagged with the low half of its address.
    assign imem_data_i = {16'hC0DE, imem_addr_o[15:0]};

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .flush_i       (flush_i),
        .flush_pc_i    (flush_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_data_i   (imem_data_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i),
        .count_o       (count_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b0; start_i = 1'b0; flush_i = 1'b0; flush_pc_i = '0;
        imem_ack_i = 1'b0; instr_ready_i = 1'b0;
        tick(); tick();
        rst_i = 1'b1;
        tick();
    endtask

    initial begin
        // ---- reset state
        rst_i = 1'b0; start_i = 1'b0; flush_i = 1'b0; flush_pc_i = '0;
        imem_ack_i = 1'b0; instr_ready_i = 1'b0;
        tick(); tick();
        chk("rst_req",   32'(imem_req_o), 32'd0);
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_addr",  imem_addr_o, 32'h0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_pc",    instr_pc_o, 32'h0);
        rst_i = 1'b1;
        tick();
        chk("idle_noreq", 32'(imem_req_o), 32'd0);

        // ---- streaming: one per cycle, first valid two cycles after start
        start_i = 1'b1; imem_ack_i = 1'b1; instr_ready_i = 1'b1;
        tick(); start_i = 1'b0;
        chk("s_req",    32'(imem_req_o), 32'd1);
        chk("s_addr0",  imem_addr_o, 32'h0);
        chk("s_nvalid", 32'(instr_valid_o), 32'd0);
        tick();
        chk("s_valid0", 32'(instr_valid_o), 32'd1);
        chk("s_pc0",    instr_pc_o, 32'h0);
        chk("s_ins0",   instr_o, 32'hC0DE_0000);
        chk("s_addr4",  imem_addr_o, 32'h4);
        tick();
        chk("s_pc4",    instr_pc_o, 32'h4);
        chk("s_ins4",   instr_o, 32'hC0DE_0004);
        tick();
        chk("s_pc8",    instr_pc_o, 32'h8);
        chk("s_cnt1",   32'(count_o), 32'd1);

        // ---- fill to full, stall, resume at 0x10
        do_reset();
        start_i = 1'b1; imem_ack_i = 1'b1; instr_ready_i = 1'b0;
        tick(); start_i = 1'b0;
        tick(); chk("f_cnt1", 32'(count_o), 32'd1);
        tick(); chk("f_cnt2", 32'(count_o), 32'd2);
        tick(); chk("f_cnt3", 32'(count_o), 32'd3);
        tick();
        chk("f_cnt4",  32'(count_o), 32'd4);
        chk("f_noreq", 32'(imem_req_o), 32'd0);
        tick(); tick();
        chk("f_hold4",  32'(count_o), 32'd4);
        chk("f_holdrq", 32'(imem_req_o), 32'd0);
        chk("f_head",   instr_pc_o, 32'h0);
        instr_ready_i = 1'b1;
        tick(); instr_ready_i = 1'b0;
        chk("f_cnt3b",  32'(count_o), 32'd3);
        chk("f_resreq", 32'(imem_req_o), 32'd1);
        chk("f_resadr", imem_addr_o, 32'h10);
        tick();
        chk("f_refull", 32'(count_o), 32'd4);
        chk("f_head4",  instr_pc_o, 32'h4);

        // ---- delayed ack: address held, one push per ack
        do_reset();
        start_i = 1'b1; imem_ack_i = 1'b0;
        tick(); start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("d_addr", imem_addr_o, 32'h0);
            chk("d_req",  32'(imem_req_o), 32'd1);
            chk("d_cnt0", 32'(count_o), 32'd0);
            tick();
        end
        imem_ack_i = 1'b1;
        tick(); imem_ack_i = 1'b0;
        chk("d_cnt1",  32'(count_o), 32'd1);
        chk("d_addr4", imem_addr_o, 32'h4);
        tick();
        chk("d_cnt1b", 32'(count_o), 32'd1);

        // ---- flush while request to 0x8 pending -> drain
        do_reset();
        start_i = 1'b1; imem_ack_i = 1'b1;
        tick(); start_i = 1'b0;
        tick(); tick();
        imem_ack_i = 1'b0;
        tick();
        chk("x_addr8", imem_addr_o, 32'h8);
        chk("x_cnt2",  32'(count_o), 32'd2);
        flush_i = 1'b1; flush_pc_i = 32'h100;
        tick(); flush_i = 1'b0;
        chk("x_cnt0",   32'(count_o), 32'd0);
        chk("x_nvalid", 32'(instr_valid_o), 32'd0);
        chk("x_stale",  imem_addr_o, 32'h8);
        chk("x_dreq",   32'(imem_req_o), 32'd1);
        tick();
        chk("x_stale2", imem_addr_o, 32'h8);
        imem_ack_i = 1'b1; instr_ready_i = 1'b1;
        tick();
        chk("x_discard", 32'(count_o), 32'd0);
        chk("x_newadr",  imem_addr_o, 32'h100);
        tick();
        chk("x_hpc",  instr_pc_o, 32'h100);
        chk("x_hins", instr_o, 32'hC0DE_0100);

        // ---- PC wrap, flush in IDLE, flush coinciding with ack
        do_reset();
        flush_i = 1'b1; flush_pc_i = 32'hFFFF_FFF8;
        tick(); flush_i = 1'b0;
        chk("w_idle", 32'(imem_req_o), 32'd0);
        chk("w_pc",   imem_addr_o, 32'hFFFF_FFF8);
        start_i = 1'b1; imem_ack_i = 1'b1; instr_ready_i = 1'b1;
        tick(); start_i = 1'b0;
        tick();
        chk("w_addrC", imem_addr_o, 32'hFFFF_FFFC);
        tick();
        chk("w_wrap", imem_addr_o, 32'h0);
        chk("w_hpc",  instr_pc_o, 32'hFFFF_FFFC);
        chk("w_hins", instr_o, 32'hC0DE_FFFC);
        flush_i = 1'b1; flush_pc_i = 32'h200;
        tick(); flush_i = 1'b0;
        chk("a_cnt0", 32'(count_o), 32'd0);
        chk("a_addr", imem_addr_o, 32'h200);
        chk("a_req",  32'(imem_req_o), 32'd1);

        // ---- reset mid-request with two entries queued
        do_reset();
        start_i = 1'b1; imem_ack_i = 1'b1;
        tick(); start_i = 1'b0;
        tick(); tick();
        imem_ack_i = 1'b0;
        chk("r_cnt2", 32'(count_o), 32'd2);
        #2 rst_i = 1'b0;
        #1;
        chk("r_req",   32'(imem_req_o), 32'd0);
        chk("r_valid", 32'(instr_valid_o), 32'd0);
        chk("r_cnt",   32'(count_o), 32'd0);
        chk("r_addr",  imem_addr_o, 32'h0);
        tick(); rst_i = 1'b1;
        tick(); tick();
        chk("r_nostart", 32'(imem_req_o), 32'd0);
        start_i = 1'b1;
        tick(); start_i = 1'b0;
        chk("r_req2",  32'(imem_req_o), 32'd1);
        chk("r_addr2", imem_addr_o, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
